// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> BUS -> DONE handshake, with byte-lane steering and load extension.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        MemRw,
  input  logic [2:0]  LoadStoreMode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_out,
  output logic        lsu_busy,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_mode;
  logic [1:0]  r_addr_lo;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_misaligned;
  logic        r_bus_err;

  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_timeout;

  // mode[1] set covers W plus the reserved encodings 011/110/111, all handled as words
  assign w_is_word    = LoadStoreMode[1];
  assign w_is_half    = (LoadStoreMode[1:0] == 2'b01);
  assign w_misaligned = (w_is_half & addr[0]) | (w_is_word & (addr[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    if (MemRw && !w_is_word) begin
      if (w_is_half) begin
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end else begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    unique case (r_addr_lo)
      2'd0: w_byte = bus_rdata[7:0];
      2'd1: w_byte = bus_rdata[15:8];
      2'd2: w_byte = bus_rdata[23:16];
      2'd3: w_byte = bus_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_load = bus_rdata;
    if (!r_mode[1]) begin
      if (r_mode[0]) begin
        w_load = r_mode[2] ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      end else begin
        w_load = r_mode[2] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_cnt;

  assign w_timeout = (r_state == ST_BUS) && !bus_ack && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_BUS) || bus_ack || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= 32'h0;
      r_bus_be     <= 4'b0000;
      r_bus_wdata  <= 32'h0;
      r_rdata      <= 32'h0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_misaligned <= 1'b0;
          r_bus_err    <= 1'b0;
          if (req_valid) begin
            if (w_misaligned) begin
              r_state      <= ST_DONE;
              r_misaligned <= 1'b1;
              r_rdata      <= 32'h0;
            end else begin
              r_state     <= ST_BUS;
              r_mode      <= LoadStoreMode;
              r_addr_lo   <= addr[1:0];
              r_bus_we    <= MemRw;
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            r_state <= ST_DONE;
            if (!r_bus_we) begin
              r_rdata <= w_load;
            end
          end else if (w_timeout) begin
            r_state   <= ST_DONE;
            r_bus_err <= 1'b1;
            r_rdata   <= 32'h0;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_misaligned <= 1'b0;
          r_bus_err    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lsu_busy   = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_BUS);
  assign done       = (r_state == ST_DONE);
  assign misaligned = r_misaligned;
  assign bus_err    = r_bus_err;
  assign bus_req    = (r_state == ST_BUS);
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_be     = r_bus_be;
  assign bus_wdata  = r_bus_wdata;
  assign rdata_out  = r_rdata;

endmodule
